axis_pattern_gen: RTL

- Parametrised AXI-stream test-pattern master for integration tops.
- Drives configurable packets onto an axi_stream_inf master port in one of four data modes, with programmable length, inter-packet gap and packet count.
- Reports progress and completion to the test harness.
- Full-handshake successor to a tied-off stream source: honours axis_tready and generates real traffic.

---
 rtl/axis_pattern_gen_if.sv | 23 ++
 rtl/axis_pattern_gen.sv | 135 +++++++++++++
 2 files changed

// File: rtl/axis_pattern_gen_if.sv
// rtl/axis_pattern_gen_if.sv - stream bus between a pattern source and its sink.
interface axi_stream_inf #(
   parameter int DSIZE = 16
);
   logic             axis_tvalid;
   logic             axis_tready;
   logic [DSIZE-1:0] axis_tdata;
   logic             axis_tlast;

   modport master (
      output axis_tvalid,
      output axis_tdata,
      output axis_tlast,
      input  axis_tready
   );

   modport slave (
      input  axis_tvalid,
      input  axis_tdata,
      input  axis_tlast,
      output axis_tready
   );
endinterface

// File: rtl/axis_pattern_gen.sv
// rtl/axis_pattern_gen.sv - stream test-pattern master with packet framing, gaps and stop.
// tdata doubles as the pattern register, so it only advances on a handshake.
module axis_pattern_gen #(
   parameter int               DSIZE = 16,
   parameter int               LSIZE = 16,
   parameter int               NSIZE = 16,
   parameter int               GSIZE = 8,
   parameter logic [DSIZE-1:0] POLY  = DSIZE'(16'hB400)
) (
   input  logic                 clock,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic [1:0]           mode,
   input  logic [DSIZE-1:0]     data_init,
   input  logic [LSIZE-1:0]     pkt_len,
   input  logic [NSIZE-1:0]     pkt_num,
   input  logic [GSIZE-1:0]     gap,
   output logic                 busy,
   output logic                 done,
   output logic [NSIZE-1:0]     pkt_cnt,
   axi_stream_inf.master        origin_inf
);
   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t           state;
   logic [1:0]       mode_r;
   logic [LSIZE-1:0] len_r;
   logic [NSIZE-1:0] num_r;
   logic [GSIZE-1:0] gap_r;
   logic [LSIZE-1:0] beat_cnt;
   logic [GSIZE-1:0] gap_cnt;
   logic             stop_req;

   logic [LSIZE-1:0] len_eff;
   logic [DSIZE-1:0] seed;
   logic [LSIZE-1:0] beat_cnt_nxt;
   logic [NSIZE-1:0] pkt_cnt_nxt;

   function automatic logic [DSIZE-1:0] next_data(input logic [1:0] m, input logic [DSIZE-1:0] d);
      case (m)
         2'd0:    next_data = d + DSIZE'(1);
         2'd1:    next_data = d;
         2'd2:    next_data = (d >> 1) ^ (d[0] ? POLY : '0);
         default: next_data = {d[DSIZE-2:0], d[DSIZE-1]};
      endcase
   endfunction

   // LFSR and walking-one would lock up on an all-zero seed.
   assign len_eff      = (pkt_len == '0) ? LSIZE'(1) : pkt_len;
   assign seed         = (mode[1] && data_init == '0) ? DSIZE'(1) : data_init;
   assign beat_cnt_nxt = beat_cnt + LSIZE'(1);
   assign pkt_cnt_nxt  = pkt_cnt + NSIZE'(1);

   always_ff @(posedge clock) begin
      if (rst) begin
         state                  <= IDLE;
         origin_inf.axis_tvalid <= 1'b0;
         origin_inf.axis_tlast  <= 1'b0;
         origin_inf.axis_tdata  <= '0;
         busy                   <= 1'b0;
         done                   <= 1'b0;
         pkt_cnt                <= '0;
         stop_req               <= 1'b0;
         mode_r                 <= 2'd0;
         len_r                  <= LSIZE'(1);
         num_r                  <= '0;
         gap_r                  <= '0;
         beat_cnt               <= '0;
         gap_cnt                <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state                  <= SEND;
                  mode_r                 <= mode;
                  len_r                  <= len_eff;
                  num_r                  <= pkt_num;
                  gap_r                  <= gap;
                  busy                   <= 1'b1;
                  pkt_cnt                <= '0;
                  beat_cnt               <= '0;
                  stop_req               <= 1'b0;
                  origin_inf.axis_tvalid <= 1'b1;
                  origin_inf.axis_tdata  <= seed;
                  origin_inf.axis_tlast  <= (len_eff == LSIZE'(1));
               end
            end
            SEND: begin
               if (stop) stop_req <= 1'b1;
               if (origin_inf.axis_tready) begin
                  origin_inf.axis_tdata <= next_data(mode_r, origin_inf.axis_tdata);
                  if (origin_inf.axis_tlast) begin
                     pkt_cnt  <= pkt_cnt_nxt;
                     beat_cnt <= '0;
                     if (stop_req || stop || (num_r != '0 && pkt_cnt_nxt == num_r)) begin
                        state                  <= IDLE;
                        origin_inf.axis_tvalid <= 1'b0;
                        origin_inf.axis_tlast  <= 1'b0;
                        busy                   <= 1'b0;
                        done                   <= 1'b1;
                        stop_req               <= 1'b0;
                     end else if (gap_r == '0) begin
                        origin_inf.axis_tlast  <= (len_r == LSIZE'(1));
                     end else begin
                        state                  <= GAP;
                        origin_inf.axis_tvalid <= 1'b0;
                        origin_inf.axis_tlast  <= 1'b0;
                        gap_cnt                <= gap_r - GSIZE'(1);
                     end
                  end else begin
                     beat_cnt              <= beat_cnt_nxt;
                     origin_inf.axis_tlast <= (beat_cnt_nxt == len_r - LSIZE'(1));
                  end
               end
            end
            GAP: begin
               if (stop) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (gap_cnt == '0) begin
                  state                  <= SEND;
                  origin_inf.axis_tvalid <= 1'b1;
                  origin_inf.axis_tlast  <= (len_r == LSIZE'(1));
               end else begin
                  gap_cnt <= gap_cnt - GSIZE'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
